// File: rtl/smu_pkg.sv
// Shared definitions for the stream supervisor: state encoding and LED colour codes.
// LED codes are packed {red, green, blue}.
package smu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_WARMUP    = 3'd1,
    ST_PREFILL   = 3'd2,
    ST_RUN       = 3'd3
  } state_e;

  typedef logic [2:0] led_t;

  localparam led_t LED_RED   = 3'b100;
  localparam led_t LED_GREEN = 3'b010;
  localparam led_t LED_BLUE  = 3'b001;
  localparam led_t LED_ALERT = 3'b110;

  // Green while streaming, amber-ish (green+red) once an underrun has ever been seen.
  function automatic led_t led_code(input state_e s, input logic udr_seen);
    case (s)
      ST_RUN:                 return udr_seen ? LED_ALERT : LED_GREEN;
      ST_WARMUP, ST_PREFILL:  return LED_BLUE;
      default:                return LED_RED;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, with a one-cycle rising-edge pulse.
// rise is combinational from the last two flops, so the FSM acts on it STAGES+1 edges after the pin.
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q_sync,
  output logic rise
);

  logic [STAGES:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-1:0], d_async};
  end

  assign q_sync = chain[STAGES-1];
  assign rise   = chain[STAGES-1] & ~chain[STAGES];

endmodule

// File: rtl/stream_supervisor.sv
// Supervisor for the I2S-to-S/PDIF path: lock qualification, frame warm-up, FIFO prefill,
// overrun/underrun accounting, frame-clock watchdog and status LEDs. All outputs registered.
module stream_supervisor
  import smu_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int WARMUP_FRAMES      = 2,
  parameter int FIFO_DEPTH         = 16,
  parameter int PREFILL            = 8,
  parameter int FCLK_TIMEOUT       = 4096,
  parameter int SYNC_STAGES        = 2,
  parameter int CNT_W              = 8,
  localparam int LEVEL_W           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  input  logic               fclk,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               sys_rst,
  output logic               write_en,
  output logic               read_en,
  output logic               led_r,
  output logic               led_g,
  output logic               led_b,
  output logic [2:0]         state_o,
  output logic [CNT_W-1:0]   overrun_cnt,
  output logic [CNT_W-1:0]   underrun_cnt
);

  localparam int LOCK_W  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int FRAME_W = $clog2(WARMUP_FRAMES + 1);
  localparam int WD_W    = $clog2(FCLK_TIMEOUT + 1);

  logic lock_s, lock_rise_unused, fclk_s_unused, fclk_rise;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_fclk (
    .clk(clk), .rst(rst), .d_async(fclk), .q_sync(fclk_s_unused), .rise(fclk_rise)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk(clk), .rst(rst), .d_async(pll_lock), .q_sync(lock_s), .rise(lock_rise_unused)
  );

  state_e             state_q, state_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic [CNT_W-1:0]   ovr_d, udr_d;
  logic               lvl_full, lvl_empty, timeout, ovr_evt, udr_evt;
  led_t               led_q;

  // Out-of-range levels are treated as full.
  assign lvl_full  = fifo_level >= LEVEL_W'(FIFO_DEPTH);
  assign lvl_empty = fifo_level == '0;
  assign timeout   = (state_q != ST_WAIT_LOCK) && (wd_cnt_q == WD_W'(FCLK_TIMEOUT - 1));
  assign ovr_evt   = (state_q == ST_RUN) && fclk_rise && lvl_full;
  assign udr_evt   = (state_q == ST_RUN) && fclk_rise && lvl_empty;

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    frame_cnt_d = frame_cnt_q;
    wd_cnt_d    = '0;
    if (state_q != ST_WAIT_LOCK) wd_cnt_d = fclk_rise ? '0 : wd_cnt_q + WD_W'(1);

    case (state_q)
      ST_WAIT_LOCK: begin
        frame_cnt_d = '0;
        if (!lock_s) lock_cnt_d = '0;
        else if (lock_cnt_q == LOCK_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d    = ST_WARMUP;
          lock_cnt_d = '0;
        end else lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
      ST_WARMUP: begin
        if (fclk_rise) begin
          if (frame_cnt_q == FRAME_W'(WARMUP_FRAMES - 1)) begin
            state_d     = ST_PREFILL;
            frame_cnt_d = '0;
          end else frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
      end
      ST_PREFILL: if (fifo_level >= LEVEL_W'(PREFILL)) state_d = ST_RUN;
      ST_RUN:     if (udr_evt) state_d = ST_PREFILL;
      default:    state_d = ST_WAIT_LOCK;
    endcase

    // Lock loss and watchdog override everything else; event counters still update below.
    if ((state_q != ST_WAIT_LOCK) && (!lock_s || timeout)) begin
      state_d     = ST_WAIT_LOCK;
      lock_cnt_d  = '0;
      frame_cnt_d = '0;
      wd_cnt_d    = '0;
    end

    ovr_d = overrun_cnt;
    if (ovr_evt && (overrun_cnt != '1)) ovr_d = overrun_cnt + CNT_W'(1);
    udr_d = underrun_cnt;
    if (udr_evt && (underrun_cnt != '1)) udr_d = underrun_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_WAIT_LOCK;
      lock_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      wd_cnt_q     <= '0;
      overrun_cnt  <= '0;
      underrun_cnt <= '0;
      sys_rst      <= 1'b1;
      write_en     <= 1'b0;
      read_en      <= 1'b0;
      led_q        <= LED_RED;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      overrun_cnt  <= ovr_d;
      underrun_cnt <= udr_d;
      sys_rst      <= state_d == ST_WAIT_LOCK;
      write_en     <= ((state_d == ST_PREFILL) || (state_d == ST_RUN)) && !lvl_full;
      read_en      <= (state_d == ST_RUN) && !lvl_empty;
      led_q        <= led_code(state_d, udr_d != '0);
    end
  end

  assign state_o               = state_q;
  assign {led_r, led_g, led_b} = led_q;

endmodule

// File: tb/tb_stream_supervisor.sv
// Bench for stream_supervisor: vector table for the main walk, hand sequences for lock-drop
// during underrun and counter saturation. Expected words flow through a scoreboard queue.
module tb_stream_supervisor;

  localparam int OUT_W = 25;

  logic       clk;
  logic       rst, pll_lock, fclk;
  logic [4:0] fifo_level;
  logic       sys_rst, write_en, read_en, led_r, led_g, led_b;
  logic [2:0] state_o;
  logic [7:0] overrun_cnt, underrun_cnt;

  stream_supervisor #(
    .LOCK_STABLE_CYCLES(8), .WARMUP_FRAMES(2), .FIFO_DEPTH(16), .PREFILL(8),
    .FCLK_TIMEOUT(64), .SYNC_STAGES(2), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .fclk(fclk), .fifo_level(fifo_level),
    .sys_rst(sys_rst), .write_en(write_en), .read_en(read_en),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .state_o(state_o),
    .overrun_cnt(overrun_cnt), .underrun_cnt(underrun_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       rst, lock, fclk;
    logic [4:0] level;
    int         cyc;
    logic [2:0] st;
    logic       sr, we, re;
    logic [2:0] led;
    logic [7:0] ovr, udr;
  } vec_t;

  vec_t             vt[$];
  logic [OUT_W-1:0] exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;

  function automatic vec_t mk(input logic r, input logic l, input logic f, input logic [4:0] lv,
                              input int c, input logic [2:0] st, input logic sr, input logic we,
                              input logic re, input logic [2:0] led, input logic [7:0] ovr,
                              input logic [7:0] udr);
    vec_t v;
    v.rst = r; v.lock = l; v.fclk = f; v.level = lv; v.cyc = c;
    v.st = st; v.sr = sr; v.we = we; v.re = re; v.led = led; v.ovr = ovr; v.udr = udr;
    return v;
  endfunction

  // scoreboard
  task automatic check_out(input string tag);
    logic [OUT_W-1:0] got, exp;
    got = {state_o, sys_rst, write_en, read_en, led_r, led_g, led_b, overrun_cnt, underrun_cnt};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", tag, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s: got st=%0d sr=%b we=%b re=%b led=%b ovr=%0d udr=%0d, exp st=%0d sr=%b we=%b re=%b led=%b ovr=%0d udr=%0d",
                 tag, got[24:22], got[21], got[20], got[19], got[18:16], got[15:8], got[7:0],
                 exp[24:22], exp[21], exp[20], exp[19], exp[18:16], exp[15:8], exp[7:0]);
      end
    end
  endtask

  // driver: called at a negedge, returns at a negedge after v.cyc rising edges
  task automatic apply(input vec_t v, input string tag);
    rst = v.rst; pll_lock = v.lock; fclk = v.fclk; fifo_level = v.level;
    exp_q.push_back({v.st, v.sr, v.we, v.re, v.led, v.ovr, v.udr});
    repeat (v.cyc) @(posedge clk);
    @(negedge clk);
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b0; fclk = 1'b0; fifo_level = '0;

    //           rst lock fclk lvl cyc st  sr we re led     ovr udr
    vt.push_back(mk(1, 0, 0,  0,  2, 0, 1, 0, 0, 3'b100, 0, 0)); // reset state
    vt.push_back(mk(0, 1, 0,  0,  9, 0, 1, 0, 0, 3'b100, 0, 0)); // lock counting
    vt.push_back(mk(0, 1, 0,  0,  1, 1, 0, 0, 0, 3'b001, 0, 0)); // WARMUP at lock+10
    vt.push_back(mk(0, 1, 1,  0,  3, 1, 0, 0, 0, 3'b001, 0, 0)); // frame 1
    vt.push_back(mk(0, 1, 0,  0,  5, 1, 0, 0, 0, 3'b001, 0, 0));
    vt.push_back(mk(0, 1, 1,  0,  3, 2, 0, 1, 0, 3'b001, 0, 0)); // frame 2 -> PREFILL
    vt.push_back(mk(0, 1, 0,  4,  2, 2, 0, 1, 0, 3'b001, 0, 0));
    vt.push_back(mk(0, 1, 0,  7,  1, 2, 0, 1, 0, 3'b001, 0, 0)); // below threshold
    vt.push_back(mk(0, 1, 0,  8,  1, 3, 0, 1, 1, 3'b010, 0, 0)); // threshold -> RUN
    vt.push_back(mk(0, 1, 0,  0,  1, 3, 0, 1, 0, 3'b010, 0, 0)); // empty, no read
    vt.push_back(mk(0, 1, 1,  0,  3, 2, 0, 1, 0, 3'b001, 0, 1)); // underrun -> PREFILL
    vt.push_back(mk(0, 1, 0, 10,  1, 3, 0, 1, 1, 3'b110, 0, 1)); // RUN with alert LED
    vt.push_back(mk(0, 1, 0, 16,  1, 3, 0, 0, 1, 3'b110, 0, 1)); // full, no write
    vt.push_back(mk(0, 1, 1, 16,  3, 3, 0, 0, 1, 3'b110, 1, 1)); // overrun, stays RUN
    vt.push_back(mk(0, 1, 0, 20,  1, 3, 0, 0, 1, 3'b110, 1, 1)); // illegal level = full
    vt.push_back(mk(0, 1, 1, 20,  3, 3, 0, 0, 1, 3'b110, 2, 1)); // overrun at illegal level
    vt.push_back(mk(0, 1, 0,  8, 63, 3, 0, 1, 1, 3'b110, 2, 1)); // fclk stalled, not yet
    vt.push_back(mk(0, 1, 0,  8,  1, 0, 1, 0, 0, 3'b100, 2, 1)); // watchdog -> WAIT_LOCK
    vt.push_back(mk(0, 1, 0,  8,  3, 0, 1, 0, 0, 3'b100, 2, 1)); // lock_cnt 3
    vt.push_back(mk(0, 0, 0,  8,  1, 0, 1, 0, 0, 3'b100, 2, 1)); // 1-cycle lock glitch
    vt.push_back(mk(0, 1, 0,  8,  9, 0, 1, 0, 0, 3'b100, 2, 1)); // count restarted
    vt.push_back(mk(0, 1, 0,  8,  1, 1, 0, 0, 0, 3'b001, 2, 1)); // delayed WARMUP
    vt.push_back(mk(0, 1, 1,  8,  3, 1, 0, 0, 0, 3'b001, 2, 1));
    vt.push_back(mk(0, 1, 0,  8,  5, 1, 0, 0, 0, 3'b001, 2, 1));
    vt.push_back(mk(0, 1, 1,  8,  3, 2, 0, 1, 0, 3'b001, 2, 1)); // PREFILL
    vt.push_back(mk(0, 1, 0,  8,  1, 3, 0, 1, 1, 3'b110, 2, 1)); // RUN

    @(negedge clk);
    for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("tbl%0d", i));

    // lock lost on the same edge as an underrun: lock wins, underrun still counted
    apply(mk(0, 0, 1, 0, 3, 0, 1, 0, 0, 3'b100, 2, 2), "lockdrop_udr");
    apply(mk(0, 1, 0, 0, 9, 0, 1, 0, 0, 3'b100, 2, 2), "relock_wait");
    apply(mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 3'b001, 2, 2), "relock_warmup");
    apply(mk(0, 1, 1, 0, 3, 1, 0, 0, 0, 3'b001, 2, 2), "relock_f1");
    apply(mk(0, 1, 0, 0, 5, 1, 0, 0, 0, 3'b001, 2, 2), "relock_gap");
    apply(mk(0, 1, 1, 0, 3, 2, 0, 1, 0, 3'b001, 2, 2), "relock_prefill");
    apply(mk(0, 1, 0, 8, 1, 3, 0, 1, 1, 3'b110, 2, 2), "relock_run");

    // repeated underruns: count saturates at 255
    for (int i = 1; i <= 300; i++) begin
      int         u;
      logic [7:0] ue;
      u  = 2 + i;
      ue = (u > 255) ? 8'd255 : u[7:0];
      apply(mk(0, 1, 1, 0, 3, 2, 0, 1, 0, 3'b001, 2, ue), $sformatf("sat_udr%0d", i));
      apply(mk(0, 1, 0, 8, 1, 3, 0, 1, 1, 3'b110, 2, ue), $sformatf("sat_run%0d", i));
      apply(mk(0, 1, 0, 0, 4, 3, 0, 1, 0, 3'b110, 2, ue), $sformatf("sat_drain%0d", i));
    end

    // synchronous reset clears the counters
    apply(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 3'b100, 0, 0), "final_reset");

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
